// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: registered pipeline stage with a one-entry skid buffer.
// in_ready comes only from local state, so back-pressure is absorbed by the
// skid register instead of rippling combinationally upstream.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | no payload held, out_valid low
// ST_ONE   | main register holds the head payload
// ST_TWO   | main holds the head, skid holds the next payload
module pipe_reg_skid #(
    parameter int unsigned      WIDTH     = 128,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             active;
    logic             push;
    logic             pop;

    // Handshake terms; rst gates in_ready so it reads low while held in reset.
    assign active    = en & ~flush;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = rst & active & (state_q != ST_TWO);
    assign push      = in_valid & in_ready;
    assign pop       = active & out_valid & out_ready;
    assign out_data  = main_q;
    assign stall_cnt = stall_cnt_q;

    // Occupancy transitions and payload movement between input, skid and main.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = '0;
        end else if (en) begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    // Unused encoding: fall back to empty rather than lock up.
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating count of cycles where a valid payload was held back downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (active && out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= NOP_VALUE;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed scenarios plus randomized traffic, all
// checked against a two-deep FIFO reference model of the stage.
module tb_pipe_reg_skid;

    localparam logic [127:0] NOP      = 128'hDEAD_BEEF_0BAD_F00D_CAFE_0123_4567_89AB;
    localparam int unsigned  STALL_MX = 65535;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic [15:0]  stall_cnt;

    logic         en4 = 1'b0;
    logic         flush4 = 1'b0;
    logic         in_valid4 = 1'b0;
    logic [7:0]   in_data4 = '0;
    logic         out_ready4 = 1'b0;
    logic         in_ready4;
    logic         out_valid4;
    logic [7:0]   out_data4;
    logic [3:0]   stall_cnt4;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    int unsigned  stall_exp = 0;

    always #5 clk = ~clk;

    pipe_reg_skid #(.WIDTH(128), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_reg_skid #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_ready_exp();
        return rst && en && !flush && (exp_q.size() < 2);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: the stage behaves as an in-order FIFO of depth two.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            stall_exp <= 0;
        end else if (flush) begin
            exp_q.delete();
        end else if (en) begin
            if (exp_q.size() != 0 && !out_ready && stall_exp < STALL_MX)
                stall_exp <= stall_exp + 1;
            if (exp_q.size() == 0) begin
                if (in_valid) exp_q.push_back(in_data);
            end else if (exp_q.size() == 1) begin
                if (out_ready) void'(exp_q.pop_front());
                if (in_valid) exp_q.push_back(in_data);
            end else begin
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Monitor: compare DUT outputs against the model head away from the edge.
    always @(negedge clk) begin
        chk("out_valid", {127'd0, out_valid}, {127'd0, exp_q.size() != 0});
        chk("in_ready", {127'd0, in_ready}, {127'd0, in_ready_exp()});
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        chk("stall_cnt", {112'd0, stall_cnt}, 128'(stall_exp));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, c;
        repeat (2) cyc();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, NOP);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_stall", {112'd0, stall_cnt}, 128'd0);
        rst = 1'b1;
        cyc();

        // First payload after reset appears one cycle later.
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 128'h12344321_24681357_12563478_11332244;
        cyc();
        chk("first_valid", {127'd0, out_valid}, 128'd1);
        chk("first_data", out_data, 128'h12344321_24681357_12563478_11332244);
        in_valid = 1'b0;
        cyc();

        // Two pushes under back-pressure fill the skid; drain in order.
        a = rand128(); b = rand128(); c = rand128();
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        cyc();
        in_data = b;
        cyc();
        in_data = c;
        chk("full_in_ready", {127'd0, in_ready}, 128'd0);
        chk("full_stall", {112'd0, stall_cnt}, 128'd1);
        cyc();
        chk("full_stall2", {112'd0, stall_cnt}, 128'd2);
        chk("full_head", out_data, a);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("drain_b", out_data, b);
        cyc();
        chk("drain_empty", {127'd0, out_valid}, 128'd0);

        // Enable low freezes a full stage even with downstream ready.
        a = rand128(); b = rand128();
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        cyc();
        in_data = b;
        cyc();
        in_valid = 1'b0; en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("frz_data", out_data, a);
            chk("frz_valid", {127'd0, out_valid}, 128'd1);
            chk("frz_stall", {112'd0, stall_cnt}, 128'd3);
        end
        en = 1'b1;
        cyc();
        chk("resume_b", out_data, b);
        cyc();

        // Flush a full stage while a new payload is offered.
        a = rand128(); b = rand128(); c = rand128();
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        cyc();
        in_data = b;
        cyc();
        flush = 1'b1; in_data = c; out_ready = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_data", out_data, NOP);
        chk("flush_stall", {112'd0, stall_cnt}, 128'd4);
        repeat (2) cyc();
        a = rand128();
        in_valid = 1'b1; in_data = a;
        cyc();
        chk("post_flush", out_data, a);
        in_valid = 1'b0;
        cyc();

        // Asynchronous reset mid-cycle in state ONE.
        a = rand128();
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        cyc();
        in_valid = 1'b0;
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_data", out_data, NOP);
        chk("arst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("arst_stall", {112'd0, stall_cnt}, 128'd0);
        @(posedge clk); #1;
        cyc();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        a = rand128();
        in_valid = 1'b1; in_data = a; out_ready = 1'b1;
        cyc();
        chk("post_rst_data", out_data, a);
        chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
        in_valid = 1'b0;
        cyc();

        // Randomized traffic; the monitor checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = $urandom_range(0, 1) == 1;
            in_data   = rand128();
            cyc();
        end
        en = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();
        chk("final_empty", {127'd0, out_valid}, 128'd0);

        // Narrow counter saturates and holds.
        en4 = 1'b1; in_valid4 = 1'b1; in_data4 = 8'h5A; out_ready4 = 1'b0;
        cyc();
        in_valid4 = 1'b0;
        repeat (14) cyc();
        chk("sat_14", {124'd0, stall_cnt4}, 128'd14);
        cyc();
        chk("sat_15", {124'd0, stall_cnt4}, 128'd15);
        repeat (6) cyc();
        chk("sat_hold", {124'd0, stall_cnt4}, 128'd15);
        chk("sat_data", {120'd0, out_data4}, 128'h5A);
        chk("sat_valid", {127'd0, out_valid4}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 128, meaning payload width in bits (e.g. {pc, alu, rs2, inst}).
REQ-002 SHALL have parameter NOP_VALUE, default {WIDTH{1'b0}}, meaning the payload presented on out_data after reset or flush.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  stage enable; 0 freezes all state except reset and flush.
REQ-007 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 SHALL have port out_data  output  WIDTH  registered payload to the next stage.
REQ-014 SHALL have port stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-015 SHALL hold a main register (drives out_data), a skid register and an occupancy state: EMPTY, ONE, TWO.
REQ-016 SHALL drive out_valid = (state != EMPTY) and out_data = main register, both directly from flops.
REQ-017 SHALL drive in_ready = en & ~flush & (state != TWO); in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 SHALL define push = in_valid & in_ready and pop = en & ~flush & out_valid & out_ready.
REQ-019 SHALL in EMPTY: push -> ONE, main <= in_data; otherwise remain EMPTY.
REQ-020 SHALL in ONE: push & pop -> ONE, main <= in_data; push & ~pop -> TWO, skid <= in_data; ~push & pop -> EMPTY; neither -> hold.
REQ-021 SHALL in TWO: pop -> ONE, main <= skid; otherwise hold (push cannot occur).
REQ-022 SHALL deliver payloads in order, with no loss or duplication; latency in_data -> out_data is exactly 1 cycle when the stage is EMPTY, or ONE with pop.
REQ-023 SHALL, when en = 0 and flush = 0, hold state, main, skid and stall_cnt unchanged and accept no transfers.
REQ-024 SHALL, when flush = 1 (regardless of en, in_valid, out_ready), on the next edge set state EMPTY and main <= NOP_VALUE, and discard skid contents and in_data.
REQ-025 SHALL increment stall_cnt by 1 on each edge where en = 1, flush = 0, out_valid = 1 and out_ready = 0, saturating at 2^CNT_W-1 without wrap.
REQ-026 SHALL NOT clear stall_cnt on flush.

Reset
REQ-027 SHALL, while rst = 0, asynchronously force state EMPTY, main = NOP_VALUE, skid = 0 and stall_cnt = 0, so that out_valid = 0, out_data = NOP_VALUE and in_ready = 0.
REQ-028 SHALL, on rst assertion mid-operation (state ONE or TWO), discard buffered payloads; the first payload accepted after release SHALL appear on out_data one cycle later.
REQ-029 SHALL release from reset with no spurious out_valid pulse; in_ready follows REQ-017 from the first edge after release.

Verification
REQ-030 SHALL check: rst low, then released, en = 1, in_valid = 1, in_data = 128'h12344321_24681357_12563478_11332244, out_ready = 1 -> next cycle out_valid = 1, out_data = that value.
REQ-031 SHALL check: out_ready = 0 with two consecutive pushes A, B -> state TWO, in_ready = 0, stall_cnt increments each cycle; out_ready = 1 -> A then B, in order, on consecutive cycles.
REQ-032 SHALL check: state TWO, en = 0 for 5 cycles with out_ready = 1 -> out_data, out_valid and stall_cnt unchanged; en = 1 -> draining resumes.
REQ-033 SHALL check: flush = 1 in state TWO with in_valid = 1 -> next cycle out_valid = 0, out_data = NOP_VALUE; A, B and the flush-cycle input never appear.
REQ-034 SHALL check: CNT_W = 4, out_ready held 0 for 20 cycles with out_valid = 1 -> stall_cnt = 4'hF and holds.
REQ-035 SHALL check: rst asserted asynchronously between clock edges in state ONE -> out_valid drops to 0 immediately, before the next edge.
